// File: rtl/rx_sample_arbiter.sv
// rtl/rx_sample_arbiter.sv - round-robin merge of per-receiver I/Q samples into one valid/ready stream
//
// Each receiver strobe is captured into a holding register. A round-robin grant then
// serializes the held samples into a single output word tagged with the receiver index
// and a last-of-set marker.
// Optional feature macro: RX_ARB_OVERRUN_EN enables the sticky per-receiver overrun flags;
// when undefined, overrun is tied low and clear_overrun is ignored.

module rx_sample_arbiter #(
  parameter int NRX = 4
) (
  input  logic              clock,
  input  logic              rst_n,
  input  logic [NRX-1:0]    rx_strobe,
  input  logic [24*NRX-1:0] rx_data_I,
  input  logic [24*NRX-1:0] rx_data_Q,
  input  logic [NRX-1:0]    enable_mask,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [2:0]        out_rx,
  output logic [23:0]       out_I,
  output logic [23:0]       out_Q,
  output logic              out_last,
  output logic [NRX-1:0]    overrun,
  input  logic              clear_overrun
);

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  state_t         r_state;
  state_t         w_state_nxt;

  logic [23:0]    r_hold_i [NRX];
  logic [23:0]    r_hold_q [NRX];
  logic [NRX-1:0] r_pend;
  logic [2:0]     r_ptr;

  logic [2:0]     r_out_rx;
  logic [23:0]    r_out_i;
  logic [23:0]    r_out_q;
  logic           r_out_last;

  logic [NRX-1:0] w_req;
  logic [NRX-1:0] w_gnt_onehot;
  logic [3:0]     w_cand;
  logic           w_gnt_any;
  logic [2:0]     w_gnt_idx;
  logic           w_do_grant;
  logic [2:0]     w_ptr_nxt;
  logic [2:0]     w_last_idx;
  logic [23:0]    w_sel_i;
  logic [23:0]    w_sel_q;

  // A receiver whose enable bit has dropped is never eligible, even in the
  // single cycle before its pend bit is cleared.
  assign w_req = r_pend & enable_mask;

  // Round-robin search: first requesting receiver at or after r_ptr, modulo NRX.
  always_comb begin
    w_gnt_any = 1'b0;
    w_gnt_idx = 3'd0;
    w_cand    = 4'd0;
    for (int i = 0; i < NRX; i++) begin
      w_cand = {1'b0, r_ptr} + 4'(i);
      if (w_cand >= 4'(NRX)) begin
        w_cand = w_cand - 4'(NRX);
      end
      for (int k = 0; k < NRX; k++) begin
        if (!w_gnt_any && (w_cand == 4'(k)) && w_req[k]) begin
          w_gnt_any = 1'b1;
          w_gnt_idx = 3'(k);
        end
      end
    end
  end

  // Highest-index enabled receiver marks the end of a round (always 0 when NRX=1).
  always_comb begin
    w_last_idx = 3'd0;
    for (int k = 0; k < NRX; k++) begin
      if (enable_mask[k]) begin
        w_last_idx = 3'(k);
      end
    end
  end

  // Select the held sample of the granted receiver and decode the grant one-hot.
  always_comb begin
    w_sel_i      = 24'd0;
    w_sel_q      = 24'd0;
    w_gnt_onehot = '0;
    for (int k = 0; k < NRX; k++) begin
      if (w_gnt_idx == 3'(k)) begin
        w_sel_i         = r_hold_i[k];
        w_sel_q         = r_hold_q[k];
        w_gnt_onehot[k] = w_do_grant;
      end
    end
  end

  // Pointer moves to the receiver after the one granted, wrapping at NRX.
  assign w_ptr_nxt = (w_gnt_idx == 3'(NRX - 1)) ? 3'd0 : (w_gnt_idx + 3'd1);

  // Next-state and grant decision: refill the output slot whenever it is empty
  // or being accepted this cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_do_grant  = 1'b0;
    case (r_state)
      ST_EMPTY: begin
        if (w_gnt_any) begin
          w_do_grant  = 1'b1;
          w_state_nxt = ST_FULL;
        end
      end
      ST_FULL: begin
        if (out_ready) begin
          if (w_gnt_any) begin
            w_do_grant = 1'b1;
          end else begin
            w_state_nxt = ST_EMPTY;
          end
        end
      end
    endcase
  end

  // State register.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Per-receiver capture and pend tracking; a same-cycle strobe wins over the
  // grant clear so the freshly captured sample stays pending.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_pend <= '0;
      for (int k = 0; k < NRX; k++) begin
        r_hold_i[k] <= 24'd0;
        r_hold_q[k] <= 24'd0;
      end
    end else begin
      for (int k = 0; k < NRX; k++) begin
        if (!enable_mask[k]) begin
          r_pend[k] <= 1'b0;
        end else if (rx_strobe[k]) begin
          r_pend[k]   <= 1'b1;
          r_hold_i[k] <= rx_data_I[24*k +: 24];
          r_hold_q[k] <= rx_data_Q[24*k +: 24];
        end else if (w_gnt_onehot[k]) begin
          r_pend[k] <= 1'b0;
        end
      end
    end
  end

  // Output word and round-robin pointer load on every grant; held otherwise.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_out_rx   <= 3'd0;
      r_out_i    <= 24'd0;
      r_out_q    <= 24'd0;
      r_out_last <= 1'b0;
      r_ptr      <= 3'd0;
    end else if (w_do_grant) begin
      r_out_rx   <= w_gnt_idx;
      r_out_i    <= w_sel_i;
      r_out_q    <= w_sel_q;
      r_out_last <= (w_gnt_idx == w_last_idx);
      r_ptr      <= w_ptr_nxt;
    end
  end

  assign out_valid = (r_state == ST_FULL);
  assign out_rx    = r_out_rx;
  assign out_I     = r_out_i;
  assign out_Q     = r_out_q;
  assign out_last  = r_out_last;

`ifdef RX_ARB_OVERRUN_EN
  logic [NRX-1:0] r_overrun;
  logic [NRX-1:0] w_ovr_set;

  // Overrun only when a pending sample is overwritten without being taken.
  assign w_ovr_set = rx_strobe & enable_mask & r_pend & ~w_gnt_onehot;

  // Sticky overrun flags; clear beats a same-cycle set.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_overrun <= '0;
    end else if (clear_overrun) begin
      r_overrun <= '0;
    end else begin
      r_overrun <= r_overrun | w_ovr_set;
    end
  end

  assign overrun = r_overrun;
`else
  logic w_unused_clear;

  assign w_unused_clear = clear_overrun;
  assign overrun        = '0;
`endif

endmodule
